out_port_fifo: RTL and testbench

//   Output-port buffer directly downstream of the 4-bit processor's OUT A path.
//   - Captures each OUT A execution as one word and queues it in a small FIFO.
//   - Drains the queue to a slow peripheral over a valid/ready handshake.
//   - Decouples CPU execution from peripheral speed; no OUT word is lost

---
 rtl/out_port_fifo_if.sv | 27 ++
 rtl/out_port_fifo.sv | 111 +++++++++++
 tb/tb_out_port_fifo.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/out_port_fifo_if.sv
// Bundles the CPU capture side and peripheral drain side of out_port_fifo.
// master drives CPU/peripheral inputs (bench or glue); slave is the FIFO itself.
interface out_port_fifo_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 3
);
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_out_en;
  logic              clear;
  logic [DATA_W-1:0] per_data;
  logic              per_valid;
  logic              per_ready;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [ADDR_W:0]   count;

  modport master (
    output cpu_data, cpu_out_en, clear, per_ready,
    input  per_data, per_valid, full, empty, overflow, count
  );

  modport slave (
    input  cpu_data, cpu_out_en, clear, per_ready,
    output per_data, per_valid, full, empty, overflow, count
  );
endinterface

// File: rtl/out_port_fifo.sv
// OUT A capture FIFO: one word per rising edge of cpu_out_en, drained over valid/ready.
// Optional OUTPORT_DEDUP_EN suppresses a capture equal to the last accepted word.
module out_port_fifo #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input logic            osc_clock,
  input logic            reset,
  out_port_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              en_prev_q;
  logic              full, empty, wr_req, pop, dup, wr_acc, mem_we;

  assign full   = (count_q == FullCount);
  assign empty  = (count_q == '0);
  assign wr_req = bus.cpu_out_en & ~en_prev_q;
  assign pop    = ~empty & bus.per_ready;
  // A simultaneous pop frees the head slot, so a full FIFO can still accept.
  assign wr_acc = wr_req & ~dup & (~full | pop);
  assign mem_we = wr_acc & ~bus.clear;

`ifdef OUTPORT_DEDUP_EN
  logic [DATA_W-1:0] last_word_q, last_word_d;
  logic              last_ok_q, last_ok_d;

  assign dup = last_ok_q & (bus.cpu_data == last_word_q);

  always_comb begin
    last_word_d = last_word_q;
    last_ok_d   = last_ok_q;
    if (bus.clear) begin
      last_ok_d = 1'b0;
    end else if (mem_we) begin
      last_word_d = bus.cpu_data;
      last_ok_d   = 1'b1;
    end
  end

  always_ff @(posedge osc_clock or negedge reset) begin
    if (!reset) begin
      last_word_q <= '0;
      last_ok_q   <= 1'b0;
    end else begin
      last_word_q <= last_word_d;
      last_ok_q   <= last_ok_d;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_acc, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (wr_req & ~dup & full & ~pop) overflow_d = 1'b1;
    end
  end

  // en_prev resets high so a level already present at reset release is not a capture.
  always_ff @(posedge osc_clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      en_prev_q  <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      en_prev_q  <= bus.cpu_out_en;
    end
  end

  always_ff @(posedge osc_clock) begin
    if (mem_we) mem_q[wr_ptr_q] <= bus.cpu_data;
  end

  assign bus.per_valid = ~empty;
  assign bus.per_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_out_port_fifo.sv
// Self-checking bench for out_port_fifo: a queue model scores every cycle at the falling edge.
// Inputs change 1 time unit after the rising edge.
module tb_out_port_fifo;

  localparam int unsigned Depth = 8;

  logic osc_clock = 1'b0;
  logic reset     = 1'b0;
  int   n_vec     = 0;
  int   n_err     = 0;

  out_port_fifo_if #(.DATA_W(4), .ADDR_W(3)) bus ();

  out_port_fifo #(.DATA_W(4), .DEPTH(Depth), .ADDR_W(3)) dut (
    .osc_clock (osc_clock),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 osc_clock = ~osc_clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard model: words pushed at capture, popped when the DUT hands them over.
  logic [3:0] exp_q[$];
  logic       ov_m, en_prev_m, last_ok_m, wr_req_m, pop_m, dup_m;
  logic [3:0] last_word_m;

  always @(negedge osc_clock) begin
    if (!reset) begin
      exp_q.delete();
      ov_m      = 1'b0;
      en_prev_m = 1'b1;
      last_ok_m = 1'b0;
    end
    check_eq("count", 32'(bus.count), 32'(exp_q.size()));
    check_eq("per_valid", 32'(bus.per_valid), 32'(exp_q.size() != 0));
    check_eq("per_data", 32'(bus.per_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    check_eq("full", 32'(bus.full), 32'(exp_q.size() == Depth));
    check_eq("empty", 32'(bus.empty), 32'(exp_q.size() == 0));
    check_eq("overflow", 32'(bus.overflow), 32'(ov_m));
    if (reset) begin
      wr_req_m = bus.cpu_out_en && !en_prev_m;
      pop_m    = (exp_q.size() != 0) && bus.per_ready;
      dup_m    = 1'b0;
`ifdef OUTPORT_DEDUP_EN
      if (wr_req_m) dup_m = last_ok_m && (bus.cpu_data == last_word_m);
`endif
      if (bus.clear) begin
        exp_q.delete();
        ov_m      = 1'b0;
        last_ok_m = 1'b0;
      end else begin
        if (pop_m) void'(exp_q.pop_front());
        if (wr_req_m && !dup_m) begin
          if (exp_q.size() < Depth) begin
            exp_q.push_back(bus.cpu_data);
            last_word_m = bus.cpu_data;
            last_ok_m   = 1'b1;
          end else begin
            ov_m = 1'b1;
          end
        end
      end
      en_prev_m = bus.cpu_out_en;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge osc_clock);
    #1;
  endtask

  task automatic write_word(input logic [3:0] d);
    bus.cpu_out_en = 1'b1;
    bus.cpu_data   = d;
    cyc(1);
    bus.cpu_out_en = 1'b0;
    bus.cpu_data   = 'z;
    cyc(1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    bus.per_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc(1);
      if (bus.empty) done = 1'b1;
    end
    check_eq("drain_done", 32'(bus.empty), 32'd1);
    bus.per_ready = 1'b0;
  endtask

  initial begin
    bus.cpu_data   = 'z;
    bus.cpu_out_en = 1'b0;
    bus.clear      = 1'b0;
    bus.per_ready  = 1'b0;
    cyc(3);
    check_eq("rst_empty", 32'(bus.empty), 32'd1);
    reset = 1'b1;
    cyc(2);

    // Capture latency into an empty FIFO
    bus.cpu_out_en = 1'b1;
    bus.cpu_data   = 4'd5;
    cyc(1);
    @(negedge osc_clock);
    check_eq("t1_valid", 32'(bus.per_valid), 32'd1);
    check_eq("t1_data", 32'(bus.per_data), 32'd5);
    check_eq("t1_count", 32'(bus.count), 32'd1);
    check_eq("t1_empty", 32'(bus.empty), 32'd0);
    cyc(1);
    bus.cpu_out_en = 1'b0;
    bus.cpu_data   = 'z;
    cyc(1);
    drain();

    // Overflow on a ninth write with no pop
    for (int i = 1; i <= 8; i++) write_word(4'(i));
    write_word(4'd9);
    check_eq("t2_full", 32'(bus.full), 32'd1);
    check_eq("t2_overflow", 32'(bus.overflow), 32'd1);
    check_eq("t2_count", 32'(bus.count), 32'd8);
    drain();
    check_eq("t2_sticky_ovf", 32'(bus.overflow), 32'd1);
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    check_eq("t2_clr_ovf", 32'(bus.overflow), 32'd0);

    // Write and pop in the same cycle while full
    for (int i = 1; i <= 8; i++) write_word(4'(i));
    bus.cpu_out_en = 1'b1;
    bus.cpu_data   = 4'd10;
    bus.per_ready  = 1'b1;
    cyc(1);
    bus.cpu_out_en = 1'b0;
    bus.cpu_data   = 'z;
    bus.per_ready  = 1'b0;
    check_eq("t3_count", 32'(bus.count), 32'd8);
    check_eq("t3_overflow", 32'(bus.overflow), 32'd0);
    drain();

    // Long-held enable gives one entry; enable high across reset release gives none
    bus.cpu_out_en = 1'b1;
    bus.cpu_data   = 4'd3;
    cyc(10);
    bus.cpu_out_en = 1'b0;
    bus.cpu_data   = 'z;
    cyc(1);
    check_eq("t4_one_entry", 32'(bus.count), 32'd1);
    bus.cpu_out_en = 1'b1;
    bus.cpu_data   = 4'd4;
    reset          = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(3);
    check_eq("t4_no_entry", 32'(bus.count), 32'd0);
    bus.cpu_out_en = 1'b0;
    bus.cpu_data   = 'z;
    cyc(1);

    // Clear beats a simultaneous capture
    for (int i = 1; i <= 4; i++) write_word(4'(i));
    check_eq("t5_pre_count", 32'(bus.count), 32'd4);
    bus.cpu_out_en = 1'b1;
    bus.cpu_data   = 4'd9;
    bus.clear      = 1'b1;
    cyc(1);
    bus.clear      = 1'b0;
    bus.cpu_out_en = 1'b0;
    bus.cpu_data   = 'z;
    check_eq("t5_count", 32'(bus.count), 32'd0);
    check_eq("t5_empty", 32'(bus.empty), 32'd1);
    check_eq("t5_overflow", 32'(bus.overflow), 32'd0);
    check_eq("t5_per_data", 32'(bus.per_data), 32'd0);
    cyc(1);

    // Repeated word
    write_word(4'd6);
    write_word(4'd6);
    write_word(4'd7);
`ifdef OUTPORT_DEDUP_EN
    check_eq("t6_count", 32'(bus.count), 32'd2);
`else
    check_eq("t6_count", 32'(bus.count), 32'd3);
`endif
    drain();

    // Random traffic scored by the model
    for (int i = 0; i < 300; i++) begin
      bus.cpu_out_en = 1'($urandom_range(0, 1));
      bus.cpu_data   = 4'($urandom_range(0, 3));
      bus.per_ready  = ($urandom_range(0, 3) == 0);
      bus.clear      = ($urandom_range(0, 60) == 0);
      cyc(1);
    end
    bus.cpu_out_en = 1'b0;
    bus.cpu_data   = 'z;
    bus.clear      = 1'b0;
    cyc(1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
